// File: rtl/instr_fetch_server.sv
// Program-memory server: takes a byte stream from a loader, then serves
// little-endian 16-bit instruction fetches to a CPU held in reset until loading ends.
module instr_fetch_server #(
  parameter int          DEPTH    = 16,
  parameter logic [15:0] NOP_INST = 16'h0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ld_valid,
  input  logic [7:0]               ld_data,
  input  logic                     ld_last,
  output logic                     ld_ready,
  input  logic                     fetch_req,
  input  logic [15:0]              fetch_addr,
  output logic [15:0]              inst,
  output logic                     inst_valid,
  output logic                     cpu_rst,
  output logic                     oob,
  output logic                     fault,
  output logic [$clog2(DEPTH):0]   prog_len
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {LOAD, RUN, FAULT} state_t;

  state_t          state, next_state;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wptr;
  logic            ld_accept;
  logic            fetch_accept;
  logic            out_of_range;
  logic [AW-1:0]   addr_lo, addr_hi;
  logic [16:0]     addr_end;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= LOAD;
    else      state <= next_state;
  end

  // Loading ends on ld_last or when the final memory slot is written.
  always_comb begin
    next_state   = state;
    ld_ready     = 1'b0;
    cpu_rst      = 1'b1;
    ld_accept    = 1'b0;
    fetch_accept = 1'b0;
    case (state)
      LOAD: begin
        ld_ready  = 1'b1;
        ld_accept = ld_valid;
        if (ld_valid && (ld_last || wptr == AW'(DEPTH - 1))) next_state = RUN;
      end
      RUN: begin
        cpu_rst      = 1'b0;
        fetch_accept = fetch_req;
        if (fetch_req && fetch_addr[0]) next_state = FAULT;
      end
      FAULT: ;
      default: next_state = LOAD;
    endcase
  end

  // The high byte address wraps inside the memory; range checks use full width.
  always_comb begin
    addr_lo      = fetch_addr[AW-1:0];
    addr_hi      = addr_lo + AW'(1);
    addr_end     = {1'b0, fetch_addr} + 17'd1;
    out_of_range = ({1'b0, fetch_addr} >= 17'(DEPTH)) || (addr_end >= 17'(prog_len));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem        <= '{default: '0};
      wptr       <= '0;
      prog_len   <= '0;
      inst       <= '0;
      inst_valid <= 1'b0;
      oob        <= 1'b0;
      fault      <= 1'b0;
    end else begin
      inst_valid <= fetch_accept;
      if (ld_accept) begin
        mem[wptr] <= ld_data;
        wptr      <= wptr + AW'(1);
        prog_len  <= prog_len + 1'b1;
      end
      // Misalignment outranks the range check.
      if (fetch_accept) begin
        if (fetch_addr[0]) begin
          inst  <= NOP_INST;
          fault <= 1'b1;
        end else if (out_of_range) begin
          inst <= NOP_INST;
          oob  <= 1'b1;
        end else begin
          inst <= {mem[addr_hi], mem[addr_lo]};
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_server.sv
// Directed bench for instr_fetch_server: loading, fetching, range/alignment
// errors, auto-finish and reset behaviour against hand-computed values.
module tb_instr_fetch_server;

  logic        clk;
  logic        rst;
  logic        ld_valid;
  logic [7:0]  ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        fetch_req;
  logic [15:0] fetch_addr;
  logic [15:0] inst;
  logic        inst_valid;
  logic        cpu_rst;
  logic        oob;
  logic        fault;
  logic [4:0]  prog_len;

  int n_compared   = 0;
  int n_mismatched = 0;

  instr_fetch_server #(.DEPTH(16), .NOP_INST(16'h0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .ld_ready   (ld_ready),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .inst       (inst),
    .inst_valid (inst_valid),
    .cpu_rst    (cpu_rst),
    .oob        (oob),
    .fault      (fault),
    .prog_len   (prog_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_byte(input logic [7:0] d, input logic last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    step();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic do_fetch(input logic [15:0] a);
    fetch_req  = 1'b1;
    fetch_addr = a;
    step();
    fetch_req  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2;
    n_compared++; if (ld_ready !== 1'b1) begin n_mismatched++; $display("FAIL reset_ld_ready: got %b, expected 1", ld_ready); end
    n_compared++; if (cpu_rst !== 1'b1) begin n_mismatched++; $display("FAIL reset_cpu_rst: got %b, expected 1", cpu_rst); end
    n_compared++; if (inst !== 16'h0000) begin n_mismatched++; $display("FAIL reset_inst: got %h, expected 0000", inst); end
    n_compared++; if (inst_valid !== 1'b0) begin n_mismatched++; $display("FAIL reset_inst_valid: got %b, expected 0", inst_valid); end
    n_compared++; if (oob !== 1'b0) begin n_mismatched++; $display("FAIL reset_oob: got %b, expected 0", oob); end
    n_compared++; if (fault !== 1'b0) begin n_mismatched++; $display("FAIL reset_fault: got %b, expected 0", fault); end
    n_compared++; if (prog_len !== 5'd0) begin n_mismatched++; $display("FAIL reset_prog_len: got %0d, expected 0", prog_len); end
    rst = 1'b1;
  endtask

  task automatic test_load_and_fetch();
    logic [7:0] prog [8];
    prog = '{8'ha0, 8'h0b, 8'h04, 8'h82, 8'hc5, 8'h44, 8'h20, 8'h02};
    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin
        n_compared++; if (cpu_rst !== 1'b1) begin n_mismatched++; $display("FAIL load_cpu_rst_held: got %b, expected 1", cpu_rst); end
      end
      load_byte(prog[i], i == 7);
    end
    n_compared++; if (prog_len !== 5'd8) begin n_mismatched++; $display("FAIL load_prog_len: got %0d, expected 8", prog_len); end
    n_compared++; if (cpu_rst !== 1'b0) begin n_mismatched++; $display("FAIL load_cpu_rst_release: got %b, expected 0", cpu_rst); end
    n_compared++; if (ld_ready !== 1'b0) begin n_mismatched++; $display("FAIL load_ld_ready_run: got %b, expected 0", ld_ready); end
    do_fetch(16'd0);
    n_compared++; if (inst !== 16'h0ba0 || inst_valid !== 1'b1) begin n_mismatched++; $display("FAIL fetch0: got %h/%b, expected 0ba0/1", inst, inst_valid); end
    do_fetch(16'd2);
    n_compared++; if (inst !== 16'h8204 || inst_valid !== 1'b1) begin n_mismatched++; $display("FAIL fetch2_b2b: got %h/%b, expected 8204/1", inst, inst_valid); end
    do_fetch(16'd6);
    n_compared++; if (inst !== 16'h0220 || inst_valid !== 1'b1) begin n_mismatched++; $display("FAIL fetch6_b2b: got %h/%b, expected 0220/1", inst, inst_valid); end
    step();
    n_compared++; if (inst !== 16'h0220 || inst_valid !== 1'b0) begin n_mismatched++; $display("FAIL idle_hold: got %h/%b, expected 0220/0", inst, inst_valid); end
  endtask

  task automatic test_oob();
    do_fetch(16'd8);
    n_compared++; if (inst !== 16'h0000 || inst_valid !== 1'b1) begin n_mismatched++; $display("FAIL oob_fetch8: got %h/%b, expected 0000/1", inst, inst_valid); end
    n_compared++; if (oob !== 1'b1 || cpu_rst !== 1'b0) begin n_mismatched++; $display("FAIL oob_flag: got oob=%b cpu_rst=%b, expected 1/0", oob, cpu_rst); end
    do_fetch(16'd4);
    n_compared++; if (inst !== 16'h44c5 || inst_valid !== 1'b1) begin n_mismatched++; $display("FAIL oob_then_fetch4: got %h/%b, expected 44c5/1", inst, inst_valid); end
    n_compared++; if (oob !== 1'b1) begin n_mismatched++; $display("FAIL oob_sticky: got %b, expected 1", oob); end
  endtask

  task automatic test_misaligned();
    do_fetch(16'd2);
    do_fetch(16'd3);
    n_compared++; if (inst !== 16'h0000 || inst_valid !== 1'b1) begin n_mismatched++; $display("FAIL mis_fetch3: got %h/%b, expected 0000/1", inst, inst_valid); end
    n_compared++; if (fault !== 1'b1 || cpu_rst !== 1'b1) begin n_mismatched++; $display("FAIL mis_fault: got fault=%b cpu_rst=%b, expected 1/1", fault, cpu_rst); end
    do_fetch(16'd0);
    n_compared++; if (inst_valid !== 1'b0 || inst !== 16'h0000) begin n_mismatched++; $display("FAIL fault_ignores_fetch: got %h/%b, expected 0000/0", inst, inst_valid); end
    load_byte(8'hee, 1'b1);
    n_compared++; if (ld_ready !== 1'b0 || prog_len !== 5'd8) begin n_mismatched++; $display("FAIL fault_ignores_load: got rdy=%b len=%0d, expected 0/8", ld_ready, prog_len); end
  endtask

  task automatic test_auto_finish();
    for (int i = 0; i < 16; i++) load_byte(8'(i), 1'b0);
    n_compared++; if (prog_len !== 5'd16) begin n_mismatched++; $display("FAIL auto_prog_len: got %0d, expected 16", prog_len); end
    n_compared++; if (cpu_rst !== 1'b0 || ld_ready !== 1'b0) begin n_mismatched++; $display("FAIL auto_run: got cpu_rst=%b rdy=%b, expected 0/0", cpu_rst, ld_ready); end
    load_byte(8'hff, 1'b1);
    n_compared++; if (prog_len !== 5'd16) begin n_mismatched++; $display("FAIL auto_no_extra: got %0d, expected 16", prog_len); end
    do_fetch(16'd14);
    n_compared++; if (inst !== 16'h0f0e || inst_valid !== 1'b1) begin n_mismatched++; $display("FAIL auto_fetch14: got %h/%b, expected 0f0e/1", inst, inst_valid); end
    n_compared++; if (oob !== 1'b0) begin n_mismatched++; $display("FAIL auto_fetch14_oob: got %b, expected 0", oob); end
    do_fetch(16'd16);
    n_compared++; if (inst !== 16'h0000 || oob !== 1'b1) begin n_mismatched++; $display("FAIL auto_fetch16: got %h oob=%b, expected 0000/1", inst, oob); end
    do_fetch(16'd0);
    n_compared++; if (inst !== 16'h0100 || inst_valid !== 1'b1) begin n_mismatched++; $display("FAIL auto_fetch0: got %h/%b, expected 0100/1", inst, inst_valid); end
  endtask

  task automatic test_mid_load_reset();
    load_byte(8'h33, 1'b0);
    load_byte(8'h44, 1'b0);
    load_byte(8'h55, 1'b0);
    #3;
    rst = 1'b0;
    #1;
    n_compared++; if (prog_len !== 5'd0 || ld_ready !== 1'b1 || cpu_rst !== 1'b1) begin n_mismatched++; $display("FAIL midrst_state: got len=%0d rdy=%b cpu_rst=%b, expected 0/1/1", prog_len, ld_ready, cpu_rst); end
    n_compared++; if (inst !== 16'h0000) begin n_mismatched++; $display("FAIL midrst_inst: got %h, expected 0000", inst); end
    rst = 1'b1;
    load_byte(8'h11, 1'b0);
    load_byte(8'h22, 1'b1);
    n_compared++; if (prog_len !== 5'd2) begin n_mismatched++; $display("FAIL reload_len: got %0d, expected 2", prog_len); end
    do_fetch(16'd0);
    n_compared++; if (inst !== 16'h2211 || inst_valid !== 1'b1) begin n_mismatched++; $display("FAIL reload_fetch0: got %h/%b, expected 2211/1", inst, inst_valid); end
    do_fetch(16'd2);
    n_compared++; if (inst !== 16'h0000 || oob !== 1'b1) begin n_mismatched++; $display("FAIL reload_fetch2: got %h oob=%b, expected 0000/1", inst, oob); end
  endtask

  task automatic test_valid_gaps();
    ld_valid = 1'b1; ld_data = 8'h55; ld_last = 1'b0;
    step();
    ld_valid = 1'b0; ld_data = 8'h66; ld_last = 1'b1;
    step();
    n_compared++; if (prog_len !== 5'd1 || cpu_rst !== 1'b1) begin n_mismatched++; $display("FAIL gap_skip: got len=%0d cpu_rst=%b, expected 1/1", prog_len, cpu_rst); end
    ld_valid = 1'b1; ld_data = 8'h77; ld_last = 1'b1;
    fetch_req = 1'b1; fetch_addr = 16'd0;
    step();
    ld_valid = 1'b0; ld_last = 1'b0; fetch_req = 1'b0;
    n_compared++; if (prog_len !== 5'd2 || cpu_rst !== 1'b0) begin n_mismatched++; $display("FAIL gap_finish: got len=%0d cpu_rst=%b, expected 2/0", prog_len, cpu_rst); end
    n_compared++; if (inst_valid !== 1'b0) begin n_mismatched++; $display("FAIL gap_transition_fetch: got %b, expected 0", inst_valid); end
    do_fetch(16'd0);
    n_compared++; if (inst !== 16'h7755 || inst_valid !== 1'b1) begin n_mismatched++; $display("FAIL gap_fetch0: got %h/%b, expected 7755/1", inst, inst_valid); end
  endtask

  initial begin
    rst        = 1'b0;
    ld_valid   = 1'b0;
    ld_data    = 8'h00;
    ld_last    = 1'b0;
    fetch_req  = 1'b0;
    fetch_addr = 16'h0000;
    test_reset();
    test_load_and_fetch();
    test_oob();
    test_misaligned();
    test_reset();
    test_auto_finish();
    test_reset();
    test_mid_load_reset();
    test_reset();
    test_valid_gaps();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
